psram_scheduler: RTL

PSRAM_SCHEDULER -- requirements
Module: psram_scheduler

---
 rtl/psram_pkg.sv | 23 ++
 rtl/psram_rr_arbiter.sv | 32 +++
 rtl/psram_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM command scheduler: read_write encodings,
// scheduler FSM states and the command-kind constants.
package psram_pkg;

  // Encoding driven on read_write towards the PSRAM driver.
  typedef enum logic [1:0] {
    RW_NONE  = 2'd0,
    RW_WRITE = 2'd1,
    RW_READ  = 2'd2
  } rw_e;

  localparam rw_e CMD_WRITE = RW_WRITE;
  localparam rw_e CMD_READ  = RW_READ;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_COMPLETE = 2'd3
  } state_e;

endpackage

// File: rtl/psram_rr_arbiter.sv
// Two-requester round-robin arbiter (write vs. read). One bit remembers which
// kind was granted last; on a tie the other kind wins. After reset the write
// requester is favoured.
module psram_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_wr_i,
  input  logic req_rd_i,
  input  logic accept_i,   // grant is being taken this cycle
  output logic gnt_wr_o,
  output logic gnt_rd_o
);

  // 1 = read was granted last (reset value makes the write win the first tie)
  logic last_rd_q;

  // Combinational grant: sole requester wins, ties go to the kind not granted last.
  always_comb begin
    gnt_wr_o = req_wr_i && (!req_rd_i || last_rd_q);
    gnt_rd_o = req_rd_i && (!req_wr_i || !last_rd_q);
  end

  // Remember the kind of the grant that was actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else if (accept_i && (gnt_wr_o || gnt_rd_o)) begin
      last_rd_q <= gnt_rd_o;
    end
  end

endmodule

// File: rtl/psram_scheduler.sv
// PSRAM command scheduler: arbitrates acquisition write bursts against
// single-word reads, sequences one command at a time to the QPI driver and
// tracks the circular write pointer.
// Optional watchdog on WAIT_END enabled by the macro PSRAM_SCHED_WATCHDOG_EN.
module psram_scheduler
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int WD_CYCLES = 255
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              qpi_on,
  input  logic              fifo_empty,
  input  logic              stop_acquisition,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              endcommand,
  input  logic              write_ended,
  input  logic [DATA_W-1:0] psram_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        read_write,
  output logic              quad_start,
  output logic              burst_mode,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] WR_STEP = (ADDR_W + 1)'(DATA_W / 8);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  rw_e                 rw_q, rw_d;
  logic                qs_q, qs_d;
  logic                burst_q, burst_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                wrapped_q, wrapped_d;
  logic [ADDR_W:0]     wr_sum;

  logic wr_pending, rd_pending, gnt_wr, gnt_rd, grant_en, wd_timeout;

  // Nothing is requested while the PSRAM is still initialising.
  assign wr_pending = qpi_on && !fifo_empty && !stop_acquisition;
  assign rd_pending = qpi_on && rd_req;
  assign grant_en   = (state_q == ST_IDLE);

  psram_rr_arbiter u_arb (
    .clk      (mem_clk),
    .rst_n    (rst_n),
    .req_wr_i (wr_pending),
    .req_rd_i (rd_pending),
    .accept_i (grant_en),
    .gnt_wr_o (gnt_wr),
    .gnt_rd_o (gnt_rd)
  );

`ifdef PSRAM_SCHED_WATCHDOG_EN
  localparam int WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;

  // Count cycles spent in WAIT_END; expire on the last allowed cycle without endcommand.
  always_comb begin
    wd_cnt_d   = (state_q == ST_WAIT_END) ? wd_cnt_q + 1'b1 : '0;
    wd_timeout = (state_q == ST_WAIT_END) && !endcommand &&
                 (wd_cnt_q == WD_W'(WD_CYCLES - 1));
    err_d      = err_q | wd_timeout;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wd_timeout = 1'b0;
  assign err        = 1'b0;
`endif

  // Write pointer advances on every driver word, wrapping modulo 2^ADDR_W.
  always_comb begin
    wr_sum    = {1'b0, wr_ptr_q} + WR_STEP;
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    if (write_ended) begin
      wr_ptr_d  = wr_sum[ADDR_W-1:0];
      wrapped_d = wrapped_q | wr_sum[ADDR_W];
    end
  end

  // Next-state and registered-output logic of the command FSM.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    rw_d       = rw_q;
    burst_d    = burst_q;
    rd_data_d  = rd_data_q;
    qs_d       = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_wr) begin
          state_d   = ST_ISSUE;
          qs_d      = 1'b1;
          address_d = wr_ptr_q;
          rw_d      = CMD_WRITE;
          burst_d   = 1'b1;
        end else if (gnt_rd) begin
          state_d   = ST_ISSUE;
          qs_d      = 1'b1;
          address_d = rd_addr;
          rw_d      = CMD_READ;
          burst_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (endcommand) begin
          state_d = ST_COMPLETE;
          if (rw_q == CMD_READ) begin
            rd_data_d  = psram_rdata;
            rd_valid_d = 1'b1;
          end
        end else if (wd_timeout) begin
          // Abandon the stuck command; a pending read gets no rd_valid.
          state_d = ST_IDLE;
          rw_d    = RW_NONE;
          burst_d = 1'b0;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
        rw_d    = RW_NONE;
        burst_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        rw_d    = RW_NONE;
        burst_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      address_q  <= '0;
      rw_q       <= RW_NONE;
      qs_q       <= 1'b0;
      burst_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      rw_q       <= rw_d;
      qs_q       <= qs_d;
      burst_q    <= burst_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign address    = address_q;
  assign read_write = rw_q;
  assign quad_start = qs_q;
  assign burst_mode = burst_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign wr_ptr     = wr_ptr_q;
  assign wrapped    = wrapped_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
